// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller channel between four clients.
// Define SDRAM_ARB_PRIO0_EN to give client 0 absolute priority over clients 1-3.
module sdram_rr_arbiter #(
  parameter int unsigned ADDR_BITS = 22
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             cl_req_i,
  input  logic [3:0]             cl_we_i,
  input  logic [4*ADDR_BITS-1:0] cl_addr_i,
  input  logic [63:0]            cl_wdata_i,
  output logic [3:0]             cl_ack_o,
  output logic [15:0]            cl_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_BITS-1:0]   mem_addr_o,
  output logic [15:0]            mem_wdata_o,
  input  logic                   mem_busy_i,
  input  logic [15:0]            mem_rdata_i
);

  localparam int unsigned NCLI = 4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StRelease} state_e;

  state_e                 state_q;
  logic [1:0]             grant_q;
  logic [1:0]             last_grant_q;
  logic [3:0]             cl_ack_q;
  logic [15:0]            cl_rdata_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [15:0]            mem_wdata_q;

  logic                   prio0;
  logic                   win_valid;
  logic [1:0]             winner;
  logic [1:0]             rr_idx;
  logic                   we_sel;
  logic [ADDR_BITS-1:0]   addr_sel;
  logic [15:0]            wdata_sel;

`ifdef SDRAM_ARB_PRIO0_EN
  assign prio0 = cl_req_i[0];
`else
  assign prio0 = 1'b0;
`endif

  // Search starts just past the last round-robin winner and wraps modulo four.
  always_comb begin
    win_valid = 1'b0;
    winner    = 2'd0;
    rr_idx    = 2'd0;
    if (prio0) begin
      win_valid = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NCLI; k++) begin
        rr_idx = last_grant_q + 2'(k);
        if (!win_valid && cl_req_i[rr_idx]) begin
          win_valid = 1'b1;
          winner    = rr_idx;
        end
      end
    end
  end

  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (winner == 2'(i)) begin
        we_sel    = cl_we_i[i];
        addr_sel  = cl_addr_i[i*ADDR_BITS +: ADDR_BITS];
        wdata_sel = cl_wdata_i[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      cl_ack_q     <= '0;
      cl_rdata_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            grant_q     <= winner;
`ifdef SDRAM_ARB_PRIO0_EN
            if (winner != 2'd0) last_grant_q <= winner;
`else
            last_grant_q <= winner;
`endif
            mem_we_q    <= we_sel;
            mem_addr_q  <= addr_sel;
            mem_wdata_q <= wdata_sel;
            mem_req_q   <= 1'b1;
            state_q     <= StIssue;
          end
        end
        // Channel busy is not yet meaningful in the cycle mem_req rises.
        StIssue: state_q <= StWait;
        StWait: begin
          if (!mem_busy_i) begin
            if (!mem_we_q) cl_rdata_q <= mem_rdata_i;
            cl_ack_q  <= 4'(1) << grant_q;
            mem_req_q <= 1'b0;
            state_q   <= StRelease;
          end
        end
        StRelease: begin
          cl_ack_q <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cl_ack_o    = cl_ack_q;
  assign cl_rdata_o  = cl_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter with a behavioural SDRAM channel model.
// Expected grant order follows SDRAM_ARB_PRIO0_EN when it is defined.
module tb_sdram_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  cl_req;
  logic [3:0]  cl_we;
  logic [87:0] cl_addr;
  logic [63:0] cl_wdata;
  logic [3:0]  cl_ack;
  logic [15:0] cl_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_busy;
  logic [15:0] mem_rdata;

  logic [21:0] caddr [4];
  logic [15:0] cwdata [4];

  int checks;
  int failures;

  logic req_prev;
  int   busy_cnt;
  int   busy_len;

  assign cl_addr  = {caddr[3], caddr[2], caddr[1], caddr[0]};
  assign cl_wdata = {cwdata[3], cwdata[2], cwdata[1], cwdata[0]};

  sdram_rr_arbiter #(.ADDR_BITS(22)) dut (
    .clk         (clk),
    .reset       (reset),
    .cl_req_i    (cl_req),
    .cl_we_i     (cl_we),
    .cl_addr_i   (cl_addr),
    .cl_wdata_i  (cl_wdata),
    .cl_ack_o    (cl_ack),
    .cl_rdata_o  (cl_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_busy_i  (mem_busy),
    .mem_rdata_i (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Channel: busy rises with mem_req and stays high for busy_len cycles.
  assign mem_busy = (mem_req && !req_prev) || (busy_cnt != 0);

  always @(posedge clk) begin
    if (reset) begin
      req_prev <= 1'b0;
      busy_cnt <= 0;
    end else begin
      req_prev <= mem_req;
      if (mem_req && !req_prev) busy_cnt <= busy_len - 1;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end

  function automatic int who(input logic [21:0] a);
    for (int i = 0; i < 4; i++) if (caddr[i] == a) return i;
    return -1;
  endfunction

  task automatic wait_req_high();
    int n;
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (cl_ack == 4'b0 && n < 100) begin @(negedge clk); n++; end
  endtask

  // Waits out the current access then the next grant; ack_fall is the ack in the first low cycle.
  task automatic wait_grant(output int cli, output int gap, output logic [3:0] ack_fall);
    int n;
    n = 0; gap = 0; cli = -1;
    while (mem_req && n < 200) begin @(negedge clk); n++; end
    ack_fall = cl_ack;
    while (!mem_req && n < 200) begin @(negedge clk); n++; gap++; end
    if (mem_req) cli = who(mem_addr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cl_req = 4'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
    checks++; if (mem_addr !== 22'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (cl_ack !== 4'h0) begin failures++; $display("FAIL reset_cl_ack got=%0h exp=0", cl_ack); end
    checks++; if (cl_rdata !== 16'h0) begin failures++; $display("FAIL reset_cl_rdata got=%0h exp=0", cl_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int n;
    busy_len = 6;
    mem_rdata = 16'hBEEF;
    caddr[1] = 22'h12345;
    cl_we = 4'b0;
    cl_req = 4'b0010;
    wait_req_high();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL read_grant got=%0h exp=1", mem_req); end
    checks++; if (mem_addr !== 22'h12345) begin failures++; $display("FAIL read_addr got=%0h exp=12345", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL read_we got=%0h exp=0", mem_we); end
    wait_ack(n);
    checks++; if (n != busy_len + 1) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", n, busy_len + 1); end
    checks++; if (cl_ack !== 4'b0010) begin failures++; $display("FAIL read_ack got=%0h exp=2", cl_ack); end
    checks++; if (cl_rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata got=%0h exp=beef", cl_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL read_release_req got=%0h exp=0", mem_req); end
    cl_req = 4'b0;
    @(negedge clk);
    checks++; if (cl_ack !== 4'b0) begin failures++; $display("FAIL read_ack_pulse got=%0h exp=0", cl_ack); end
    caddr[1] = 22'h02000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_contention();
    int exp_order [6];
    int ngrants;
    int cli;
    int prev;
    int gap;
    logic [3:0] ack_fall;
`ifdef SDRAM_ARB_PRIO0_EN
    exp_order = '{0, 0, 0, 1, 2, 3};
    ngrants = 6;
`else
    exp_order = '{0, 1, 2, 3, 0, 0};
    ngrants = 5;
`endif
    busy_len = 2;
    cl_req = 4'b1111;
    do_reset();
    prev = -1;
    for (int g = 0; g < ngrants; g++) begin
      wait_grant(cli, gap, ack_fall);
      checks++; if (cli != exp_order[g]) begin failures++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", g, cli, exp_order[g]); end
      if (g > 0) begin
        checks++; if (gap < 1) begin failures++; $display("FAIL contention_gap[%0d] got=%0d exp>=1", g, gap); end
        checks++; if (ack_fall !== 4'(1 << prev)) begin failures++; $display("FAIL contention_ack[%0d] got=%0h exp=%0h", g, ack_fall, 4'(1 << prev)); end
      end
      prev = cli;
`ifdef SDRAM_ARB_PRIO0_EN
      if (g == 2) cl_req = 4'b1110;
`endif
    end
    cl_req = 4'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_write_withdraw();
    int n;
    int held_bad;
    held_bad = 0;
    busy_len = 3;
    mem_rdata = 16'h1234;
    cl_we = 4'b0100;
    cwdata[2] = 16'hA5A5;
    cl_req = 4'b0100;
    wait_req_high();
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL write_we got=%0h exp=1", mem_we); end
    checks++; if (mem_wdata !== 16'hA5A5) begin failures++; $display("FAIL write_wdata got=%0h exp=a5a5", mem_wdata); end
    checks++; if (mem_addr !== 22'h03000) begin failures++; $display("FAIL write_addr got=%0h exp=3000", mem_addr); end
    cl_req = 4'b0;
    cl_we = 4'b0;
    cwdata[2] = 16'h0000;
    caddr[2] = 22'h3FFFF;
    n = 0;
    while (cl_ack == 4'b0 && n < 50) begin
      @(negedge clk);
      n++;
      if (mem_wdata !== 16'hA5A5 || mem_addr !== 22'h03000 || mem_we !== 1'b1) held_bad++;
    end
    checks++; if (held_bad != 0) begin failures++; $display("FAIL write_fields_held got=%0d exp=0", held_bad); end
    checks++; if (cl_ack !== 4'b0100) begin failures++; $display("FAIL write_ack got=%0h exp=4", cl_ack); end
    checks++; if (cl_rdata !== 16'hBEEF) begin failures++; $display("FAIL write_rdata_held got=%0h exp=beef", cl_rdata); end
    caddr[2] = 22'h03000;
    @(negedge clk);
    checks++; if (cl_ack !== 4'b0) begin failures++; $display("FAIL write_ack_pulse got=%0h exp=0", cl_ack); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_wait();
    int n;
    busy_len = 10;
    cl_req = 4'b0001;
    wait_req_high();
    repeat (2) @(negedge clk);
    checks++; if (mem_busy !== 1'b1) begin failures++; $display("FAIL rstwait_busy got=%0h exp=1", mem_busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstwait_mem_req got=%0h exp=0", mem_req); end
    checks++; if (cl_ack !== 4'b0) begin failures++; $display("FAIL rstwait_ack got=%0h exp=0", cl_ack); end
    cl_req = 4'b1000;
    @(negedge clk);
    reset = 1'b0;
    busy_len = 2;
    wait_req_high();
    checks++; if (who(mem_addr) != 3) begin failures++; $display("FAIL rstwait_grant got=%0d exp=3", who(mem_addr)); end
    wait_ack(n);
    checks++; if (cl_ack !== 4'b1000) begin failures++; $display("FAIL rstwait_ack3 got=%0h exp=8", cl_ack); end
    cl_req = 4'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_early_drop();
    int n;
    int bad;
    busy_len = 4;
    cl_req = 4'b0001;
    wait_req_high();
    cl_req = 4'b0011;
    @(negedge clk);
    cl_req = 4'b0001;
    wait_ack(n);
    checks++; if (cl_ack !== 4'b0001) begin failures++; $display("FAIL drop_ack0 got=%0h exp=1", cl_ack); end
    cl_req = 4'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || cl_ack[1]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL drop_client1 got=%0d exp=0", bad); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    cl_req = 4'b0;
    cl_we = 4'b0;
    busy_len = 2;
    mem_rdata = 16'h0;
    for (int i = 0; i < 4; i++) begin
      caddr[i] = 22'(32'h1000 * (i + 1));
      cwdata[i] = 16'(32'h1111 * (i + 1));
    end
    test_reset();
    test_single_read();
    test_contention();
    test_write_withdraw();
    test_reset_wait();
    test_early_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
